// File: rtl/uart_pkg.sv
// Shared UART-side constants and types for the ASCON result transmit path.
package uart_pkg;

   localparam int unsigned NB_WAVE_BYTES = 184;
   localparam int unsigned NB_TAG_BYTES  = 16;
   localparam int unsigned NB_TX_BYTES   = NB_WAVE_BYTES + NB_TAG_BYTES;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StWaitAck,
      StWaitDone,
      StFinish
   } tx_state_t;

endpackage

// File: rtl/cipher_tx_serializer.sv
// Streams a snapshot of {wave, tag} to the UART one byte at a time, MSB byte first,
// using the UART load/busy handshake with an acknowledge timeout.
module cipher_tx_serializer
   import uart_pkg::*;
#(
   parameter int unsigned NB_WAVE_BYTES = uart_pkg::NB_WAVE_BYTES,
   parameter int unsigned NB_TAG_BYTES  = uart_pkg::NB_TAG_BYTES,
   parameter int unsigned ACK_TIMEOUT   = 15
) (
   input  logic                         clock_i,
   input  logic                         resetb_i,
   input  logic                         start_i,
   input  logic [8*NB_WAVE_BYTES-1:0]   wave_i,
   input  logic [8*NB_TAG_BYTES-1:0]    tag_i,
   input  logic                         TxBusy_i,
   output logic [7:0]                   TxByte_o,
   output logic                         Load_o,
   output logic                         busy_o,
   output logic                         done_o,
   output logic                         err_o
);

   localparam int unsigned SrW      = 8 * (NB_WAVE_BYTES + NB_TAG_BYTES);
   localparam logic [7:0]  LastByte = 8'(NB_WAVE_BYTES + NB_TAG_BYTES - 1);
   localparam logic [3:0]  TmoLast  = 4'(ACK_TIMEOUT - 1);

   tx_state_t        state_q, state_d;
   logic [SrW-1:0]   sr_q, sr_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [3:0]       tmo_q, tmo_d;
   logic [7:0]       tx_byte_q, tx_byte_d;
   logic             load_q, load_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      err_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               sr_d    = {wave_i, tag_i};
               cnt_d   = '0;
               state_d = StLoad;
            end
         end
         StLoad: begin
            tmo_d   = '0;
            state_d = StWaitAck;
         end
         StWaitAck: begin
            // The error fires on the edge where the count would reach ACK_TIMEOUT.
            if (TxBusy_i) begin
               state_d = StWaitDone;
            end else if (tmo_q == TmoLast) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end else begin
               tmo_d = tmo_q + 4'd1;
            end
         end
         StWaitDone: begin
            if (!TxBusy_i) begin
               sr_d = {sr_q[SrW-9:0], 8'h00};
               if (cnt_q == LastByte) begin
                  state_d = StFinish;
               end else begin
                  cnt_d   = cnt_q + 8'd1;
                  state_d = StLoad;
               end
            end
         end
         StFinish: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Outputs are registered from the next state so they line up with the state they describe.
      load_d    = (state_d == StLoad);
      busy_d    = (state_d != StIdle);
      done_d    = (state_d == StFinish);
      tx_byte_d = load_d ? sr_d[SrW-1 -: 8] : tx_byte_q;
   end

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         state_q   <= StIdle;
         sr_q      <= '0;
         cnt_q     <= '0;
         tmo_q     <= '0;
         tx_byte_q <= '0;
         load_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         cnt_q     <= cnt_d;
         tmo_q     <= tmo_d;
         tx_byte_q <= tx_byte_d;
         load_q    <= load_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign TxByte_o = tx_byte_q;
   assign Load_o   = load_q;
   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign err_o    = err_q;

endmodule

// File: tb/tb_cipher_tx_serializer.sv
// Self-checking bench for cipher_tx_serializer: a UART responder model on the falling edge,
// and an expected byte list built directly from the wave/tag byte ordering rules.
module tb_cipher_tx_serializer;

   logic           clock_i = 1'b0;
   logic           resetb_i = 1'b0;
   logic           start_i = 1'b0;
   logic [1471:0]  wave_i = '0;
   logic [127:0]   tag_i = '0;
   logic           TxBusy_i = 1'b0;
   logic [7:0]     TxByte_o;
   logic           Load_o;
   logic           busy_o;
   logic           done_o;
   logic           err_o;

   cipher_tx_serializer dut (
      .clock_i  (clock_i),
      .resetb_i (resetb_i),
      .start_i  (start_i),
      .wave_i   (wave_i),
      .tag_i    (tag_i),
      .TxBusy_i (TxBusy_i),
      .TxByte_o (TxByte_o),
      .Load_o   (Load_o),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .err_o    (err_o)
   );

   always #5 clock_i = ~clock_i;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];
   int  load_cnt, done_cnt, err_cnt;
   int  first_load_cyc, last_fall_cyc, done_cyc, err_cyc;
   int  hold_cnt;
   int  fixed_hold = 10;
   bit  uart_en = 1'b1;

   always @(posedge clock_i) cyc++;

   // UART responder and monitor; busy is held hold_cnt full cycles after each load.
   always @(negedge clock_i) begin
      if (!resetb_i) begin
         TxBusy_i = 1'b0;
         hold_cnt = 0;
      end else begin
         if (Load_o) begin
            if (load_cnt == 0) first_load_cyc = cyc;
            rx_q.push_back(TxByte_o);
            load_cnt++;
            if (uart_en) begin
               TxBusy_i = 1'b1;
               hold_cnt = (fixed_hold != 0) ? fixed_hold : int'($urandom_range(2, 12));
            end
         end else if (TxBusy_i) begin
            hold_cnt--;
            if (hold_cnt == 0) begin
               TxBusy_i      = 1'b0;
               last_fall_cyc = cyc;
            end
         end
         if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (err_o) begin
            err_cnt++;
            err_cyc = cyc;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      rx_q.delete();
      load_cnt = 0;
      done_cnt = 0;
      err_cnt  = 0;
      first_load_cyc = -1;
      last_fall_cyc  = -1;
      done_cyc = -1;
      err_cyc  = -1;
   endtask

   // Wave bytes MSB-first, then tag bytes MSB-first.
   task automatic build_exp();
      exp_q.delete();
      for (int n = 0; n < 184; n++) exp_q.push_back(wave_i[1471-8*n -: 8]);
      for (int n = 0; n < 16; n++) exp_q.push_back(tag_i[127-8*n -: 8]);
   endtask

   task automatic fill_ordered();
      for (int n = 0; n < 184; n++) wave_i[1471-8*n -: 8] = 8'(n % 256);
      for (int n = 0; n < 16; n++) tag_i[127-8*n -: 8] = 8'(8'hF0 + n);
   endtask

   task automatic fill_random();
      for (int i = 0; i < 46; i++) wave_i[32*i +: 32] = $urandom();
      for (int i = 0; i < 4; i++) tag_i[32*i +: 32] = $urandom();
   endtask

   task automatic pulse_start();
      @(negedge clock_i);
      start_i = 1'b1;
      @(negedge clock_i);
      start_i = 1'b0;
   endtask

   task automatic wait_end(input string tag, input int budget);
      int d0 = done_cnt;
      int e0 = err_cnt;
      int i = 0;
      while (i < budget && done_cnt == d0 && err_cnt == e0) begin
         @(negedge clock_i);
         #1;
         i++;
      end
      check({tag, "_no_hang"}, 32'(i < budget), 32'd1);
   endtask

   task automatic wait_loads(input string tag, input int n);
      int i = 0;
      while (i < 5000 && load_cnt < n) begin
         @(negedge clock_i);
         #1;
         i++;
      end
      check({tag, "_reach_load"}, 32'(i < 5000), 32'd1);
   endtask

   task automatic check_stream(input string tag);
      int mism = 0;
      for (int i = 0; i < 200; i++) begin
         if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) mism++;
      end
      check({tag, "_loads"}, 32'(rx_q.size()), 32'd200);
      check({tag, "_byte_mism"}, 32'(mism), 32'd0);
      check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
      check({tag, "_done_lat"}, 32'(done_cyc - last_fall_cyc), 32'd1);
   endtask

   initial begin
      logic [7:0] exp_first;

      // Reset values
      clear_mon();
      #1;
      check("rst_out", {TxByte_o, 4'h0, Load_o, busy_o, done_o, err_o}, 32'h0);
      #30;
      resetb_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock_i);
         check("idle_out", {TxByte_o, 4'h0, Load_o, busy_o, done_o, err_o}, 32'h0);
      end

      // Ordered stream, fixed 10-cycle UART busy
      fill_ordered();
      build_exp();
      clear_mon();
      fixed_hold = 10;
      pulse_start();
      check("ord_start_busy_load", {30'h0, busy_o, Load_o}, 32'h3);
      check("ord_first_byte", 32'(TxByte_o), 32'h00);
      wait_end("ord", 5000);
      check_stream("ord");
      check("ord_last_byte", 32'(rx_q[199]), 32'hFF);
      check("ord_busy_in_finish", 32'(busy_o), 32'd1);
      // Start coinciding with FINISH is ignored
      start_i = 1'b1;
      @(negedge clock_i);
      start_i = 1'b0;
      check("fin_done_falls", {30'h0, busy_o, done_o}, 32'h0);
      repeat (5) @(negedge clock_i);
      check("fin_start_ignored", 32'(load_cnt), 32'd200);

      // Snapshot: wave changes after start, random data and random busy lengths
      fill_random();
      build_exp();
      clear_mon();
      fixed_hold = 0;
      pulse_start();
      wave_i = {184{8'hAA}};
      wait_end("snap", 5000);
      check_stream("snap");

      // Ignored start during byte 10
      fill_random();
      build_exp();
      clear_mon();
      pulse_start();
      wait_loads("ign", 10);
      pulse_start();
      wait_end("ign", 5000);
      check_stream("ign");

      // Timeout: UART never acknowledges
      clear_mon();
      uart_en = 1'b0;
      pulse_start();
      wait_end("tmo", 100);
      check("tmo_err_cnt", 32'(err_cnt), 32'd1);
      check("tmo_done_cnt", 32'(done_cnt), 32'd0);
      check("tmo_loads", 32'(load_cnt), 32'd1);
      check("tmo_err_lat", 32'(err_cyc - first_load_cyc), 32'd16);
      @(negedge clock_i);
      check("tmo_after", {30'h0, busy_o, err_o}, 32'h0);
      repeat (10) @(negedge clock_i);
      check("tmo_quiet", 32'(load_cnt + done_cnt), 32'd1);
      uart_en = 1'b1;

      // Reset mid-operation after byte 50, then resend from byte 0x00
      fill_ordered();
      build_exp();
      clear_mon();
      pulse_start();
      wait_loads("mid", 51);
      @(negedge clock_i);
      resetb_i = 1'b0;
      #1;
      check("mid_rst_out", {TxByte_o, 4'h0, Load_o, busy_o, done_o, err_o}, 32'h0);
      repeat (3) @(negedge clock_i);
      check("mid_no_done_err", 32'(done_cnt + err_cnt), 32'd0);
      resetb_i = 1'b1;
      @(negedge clock_i);
      #1;
      clear_mon();
      pulse_start();
      exp_first = exp_q[0];
      check("mid_restart_byte0", 32'(TxByte_o), 32'(exp_first));
      wait_end("mid", 5000);
      check_stream("mid");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
